// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the odd-divider reconfiguration controller:
//   - FSM state encoding
//   - default hold / settle timing
//   - divisor width constants and the divisor legality check
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DIV_W            = 16;
    localparam int SCNT_W           = 17;  // one bit wider than a divisor
    localparam int HOLD_CYC_DEF     = 4;
    localparam int SETTLE_EXTRA_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_ACK    = 3'd5
    } state_e;

    // The divider only implements odd ratios; 0 selects bypass and is legal.
    function automatic logic div_rejected(input logic [DIV_W-1:0] d);
        return (d[0] == 1'b0) && (d != '0);
    endfunction

endpackage

// File: rtl/clk_div_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req_i [1:0] : request vector
//   ptr_i       : preferred requester when both request
//   gnt_o [1:0] : one-hot grant (all zero when nothing requests)
// A lone request always wins; the pointer only breaks ties.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Sequences a divisor change on an external odd clock divider for two
// requesters: arbitrate, reject even divisors, hold the divider in reset,
// load the new divisor, wait for it to settle, then acknowledge.
//
// Parameters
//   HOLD_CYC     : cycles the divider reset is held before the load
//   SETTLE_EXTRA : cycles added to the divisor for the settle wait
// Ports
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-low reset
//   i_req[1:0]  : level request per requester, held until acknowledged
//   i_div0/1    : divisor requested by requester 0 / 1
//   o_ack[1:0]  : one-cycle completion pulse for the served requester
//   o_err       : qualifies o_ack, 1 = request rejected
//   o_busy      : high whenever the controller is not idle
//   o_div_rst   : active-low reset to the divider
//   o_divisor   : divisor to the divider, 0 = bypass
// All outputs are registered from the next state so they line up with it.
// -----------------------------------------------------------------------------
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int HOLD_CYC     = HOLD_CYC_DEF,
    parameter int SETTLE_EXTRA = SETTLE_EXTRA_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req,
    input  logic [DIV_W-1:0] i_div0,
    input  logic [DIV_W-1:0] i_div1,
    output logic [1:0]       o_ack,
    output logic             o_err,
    output logic             o_busy,
    output logic             o_div_rst,
    output logic [DIV_W-1:0] o_divisor
);

    // Down counters stop at zero, so the loaded value is the length minus one.
    localparam logic [DIV_W-1:0]  HOLD_LD =
        (HOLD_CYC > 0) ? DIV_W'(HOLD_CYC - 1) : '0;
    localparam logic [SCNT_W-1:0] SETTLE_EXTRA_W = SCNT_W'(SETTLE_EXTRA);

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               win_q, win_d;
    logic [DIV_W-1:0]   pend_q, pend_d;
    logic [DIV_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SCNT_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [SCNT_W-1:0]  settle_tot;
    logic [SCNT_W-1:0]  settle_ld;

    logic [1:0]         ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               div_rst_q, div_rst_d;
    logic [DIV_W-1:0]   divisor_q, divisor_d;

    logic [1:0]         gnt;

    rr_arb2 u_arb (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    // Settle length computed 17 bits wide so 16'hFFFF + extra cannot wrap.
    always_comb begin
        settle_tot = {1'b0, pend_q} + SETTLE_EXTRA_W;
        settle_ld  = (settle_tot == '0) ? '0 : settle_tot - 1'b1;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|i_req) state_d = ST_CHECK;
            ST_CHECK:  state_d = div_rejected(pend_q) ? ST_ACK : ST_HOLD;
            ST_HOLD:   if (hold_cnt_q == '0) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SETTLE;
            ST_SETTLE: if (settle_cnt_q == '0) state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Arbitration, latching and counters
    always_comb begin
        ptr_d        = ptr_q;
        win_d        = win_q;
        pend_d       = pend_q;
        hold_cnt_d   = hold_cnt_q;
        settle_cnt_d = settle_cnt_q;

        // Requests are only looked at in IDLE; the latched copy drives the rest.
        if (state_q == ST_IDLE && (|i_req)) begin
            win_d  = gnt[1];
            pend_d = gnt[0] ? i_div0 : i_div1;
        end

        // ACK is only ever entered from CHECK or SETTLE, so this is entry.
        if (state_d == ST_ACK) begin
            ptr_d = ~win_q;
        end

        if (state_q == ST_CHECK) begin
            hold_cnt_d = HOLD_LD;
        end else if (state_q == ST_HOLD && hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
        end

        if (state_q == ST_LOAD) begin
            settle_cnt_d = settle_ld;
        end else if (state_q == ST_SETTLE && settle_cnt_q != '0) begin
            settle_cnt_d = settle_cnt_q - 1'b1;
        end
    end

    // Output logic, decoded from the state being entered
    always_comb begin
        ack_d     = '0;
        err_d     = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        div_rst_d = 1'b1;
        divisor_d = divisor_q;
        case (state_d)
            ST_HOLD: div_rst_d = 1'b0;
            ST_LOAD: begin
                div_rst_d = 1'b0;
                divisor_d = pend_q;
            end
            ST_ACK: begin
                ack_d[win_q] = 1'b1;
                err_d        = (state_q == ST_CHECK);  // only the reject path skips SETTLE
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ptr_q        <= 1'b0;
            win_q        <= 1'b0;
            hold_cnt_q   <= '0;
            settle_cnt_q <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            div_rst_q    <= 1'b0;
            divisor_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            hold_cnt_q   <= hold_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            div_rst_q    <= div_rst_d;
            divisor_q    <= divisor_d;
        end
    end

    // Pending divisor is pure data and is always written before use.
    always_ff @(posedge i_clk) begin
        pend_q <= pend_d;
    end

    assign o_ack     = ack_q;
    assign o_err     = err_q;
    assign o_busy    = busy_q;
    assign o_div_rst = div_rst_q;
    assign o_divisor = divisor_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Scoreboard bench for clk_div_ctrl: each request pushes its expected ack,
// error flag, divisor and ack cycle; acks from the DUT pop and compare.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int H = 4;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] div0 = 16'd0;
    logic [15:0] div1 = 16'd0;
    logic [1:0]  ack;
    logic        err;
    logic        busy;
    logic        div_rst;
    logic [15:0] divisor;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int err_out = 0;

    typedef struct {
        logic [1:0]  ack;
        logic        err;
        logic [15:0] div;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic        ptr_m = 1'b0;
    logic [15:0] div_m = 16'd0;

    clk_div_ctrl #(.HOLD_CYC(H), .SETTLE_EXTRA(S)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_div0    (div0),
        .i_div1    (div1),
        .o_ack     (ack),
        .o_err     (err),
        .o_busy    (busy),
        .o_div_rst (div_rst),
        .o_divisor (divisor)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [15:0] d, input logic rej);
        return rej ? 3 : (1 + 1 + H + 1 + int'(d) + S + 1);
    endfunction

    // Drive a request (called just after a falling edge with the DUT idle)
    // and push the expected outcome(s) in service order.
    task automatic issue(input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1);
        int          ack_at;
        int          n;
        logic        idx;
        logic [15:0] d;
        logic        rej;
        exp_t        e;
        div0   = d0;
        div1   = d1;
        req    = r;
        ack_at = cyc - 1;
        n      = (r == 2'b11) ? 2 : 1;
        idx    = (r == 2'b11) ? ptr_m : r[1];
        for (int k = 0; k < n; k++) begin
            if (k == 1) idx = ~idx;
            d      = idx ? d1 : d0;
            rej    = (d[0] == 1'b0) && (d != 16'd0);
            ack_at = ack_at + lat(d, rej);
            ptr_m  = ~idx;
            if (!rej) div_m = d;
            e.ack = idx ? 2'b10 : 2'b01;
            e.err = rej;
            e.div = div_m;
            e.cyc = ack_at;
            sbq.push_back(e);
        end
    endtask

    // Watch the DUT until all expected acks arrive and it goes idle.
    task automatic run(input int budget, input bit scramble, output int lowcnt);
        exp_t e;
        lowcnt = 0;
        for (int n = 0; n < budget && (sbq.size() != 0 || busy); n++) begin
            @(negedge clk);
            if (!div_rst) lowcnt++;
            if (scramble && n == 3) begin
                div0 = 16'h1235;
                div1 = 16'h5679;
            end
            if (ack == 2'b00) begin
                if (err) err_out++;
            end else if (sbq.size() == 0) begin
                chk("spurious_ack", {30'd0, ack}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("ack", {30'd0, ack}, {30'd0, e.ack});
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("divisor", {16'd0, divisor}, {16'd0, e.div});
                chk("ack_cycle", cyc, e.cyc);
                req = req & ~ack;
            end
        end
        if (sbq.size() != 0 || busy) chk("timeout_pending", sbq.size(), 32'd0);
    endtask

    initial begin
        int lowc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_div_rst", {31'd0, div_rst}, 32'd0);
        chk("rst_divisor", {16'd0, divisor}, 32'd0);

        // First cycle after release: idle, divider out of reset, bypass
        rst = 1'b1;
        @(negedge clk);
        chk("rel_div_rst", {31'd0, div_rst}, 32'd1);
        chk("rel_divisor", {16'd0, divisor}, 32'd0);
        chk("rel_busy", {31'd0, busy}, 32'd0);

        // Even divisor from requester 1 is rejected
        issue(2'b10, 16'd0, 16'd4);
        run(100, 1'b0, lowc);
        chk("rej_lowcnt", lowc, 32'd0);

        // Divisor 3 from requester 0, inputs disturbed after the latch
        issue(2'b01, 16'd3, 16'd0);
        run(200, 1'b1, lowc);
        chk("d3_lowcnt", lowc, H + 1);

        // Requester 1 alone wins even though the pointer favours it anyway
        issue(2'b10, 16'd0, 16'd1);
        run(200, 1'b1, lowc);
        chk("d1_lowcnt", lowc, H + 1);

        // Both at once: pointer decides, loser served next
        issue(2'b11, 16'd5, 16'd7);
        run(300, 1'b0, lowc);
        chk("both_lowcnt", lowc, 2 * (H + 1));

        // Again: if the pointer ended at 0, requester 0 wins first
        issue(2'b11, 16'd1, 16'd3);
        run(300, 1'b0, lowc);
        chk("both2_lowcnt", lowc, 2 * (H + 1));

        // Divisor 0 (bypass) is accepted
        issue(2'b01, 16'd0, 16'd9);
        run(200, 1'b0, lowc);
        chk("d0_lowcnt", lowc, H + 1);

        // Reset during SETTLE aborts without an ack; held request restarts
        issue(2'b01, 16'd7, 16'd0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack", {30'd0, ack}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_div_rst", {31'd0, div_rst}, 32'd0);
        chk("mid_rst_divisor", {16'd0, divisor}, 32'd0);
        sbq.delete();
        ptr_m = 1'b0;
        div_m = 16'd0;
        rst   = 1'b1;
        issue(2'b01, 16'd7, 16'd0);
        run(200, 1'b0, lowc);
        chk("retry_lowcnt", lowc, H + 1);

        // Largest divisor: settle count must not wrap
        issue(2'b01, 16'hFFFF, 16'd0);
        run(70000, 1'b0, lowc);
        chk("max_lowcnt", lowc, H + 1);

        chk("err_outside_ack", err_out, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
